async_fifo_wr_ctrl: RTL and testbench
=====================================

// Module: async_fifo_wr_ctrl
// PURPOSE
//  Write-side controller for the async FIFO, running in the write clock domain.
//  Accepts a valid/ready stream and drives the FIFO RAM write port.
//  Keeps a speculative write pointer and a committed write pointer, and
//  publishes the committed pointer in Gray code to the read domain.
//  Packet mode commits whole packets on s_last; aborted or oversize packets are rewound.
// PARAMETERS
//  ADDR_W         4  RAM address width; DEPTH = 2**ADDR_W; pointers are ADDR_W+1 bits
//  AFULL_THRESH   2  almost_full asserts when free_cnt <= AFULL_THRESH
//  PKT_MODE       1  1: commit on s_last, honour s_abort; 0: commit every beat
// PORTS
//  clk            in   1         write-domain clock
//  rst_n          in   1         asynchronous active-low reset
//  s_valid        in   1         write beat valid
//  s_ready        out  1         beat accepted when s_valid & s_ready
//  s_last         in   1         last beat of packet (PKT_MODE=1)
//  s_abort        in   1         discard current packet; qualifies a valid beat
//  rptr_gray_sync in   ADDR_W+1  read pointer, Gray code, already synchronised to clk
//  mem_wen        out  1         RAM write enable (combinational)
//  mem_waddr      out  ADDR_W    RAM write address = spec_bin[ADDR_W-1:0]
//  wptr_gray      out  ADDR_W+1  committed write pointer, Gray code, registered
//  full           out  1         spec_bin - rbin_r == DEPTH
//  almost_full    out  1         free_cnt <= AFULL_THRESH
//  free_cnt       out  ADDR_W+1  DEPTH - (spec_bin - rbin_r)
//  pkt_dropped    out  1         one-cycle pulse when a packet is rewound
// BEHAVIOUR
//  Reset:
//   - spec_bin, commit_bin, rbin_r and wptr_gray are all 0; state is IDLE.
//   - full=0, free_cnt=DEPTH, almost_full=(DEPTH<=AFULL_THRESH), pkt_dropped=0, mem_wen=0.
//   - Reset mid-packet discards all uncommitted beats.
//  Read pointer: rbin_r <= gray2bin(rptr_gray_sync) each cycle. Read-side frees take 1 cycle to show.
//  Arithmetic: all pointer arithmetic is modulo 2**(ADDR_W+1); counters wrap naturally.
//  s_ready:
//   - IDLE/PKT: s_ready = !full.
//   - DROP: s_ready = 1, and every beat is consumed and discarded.
//  mem_wen = accept & state!=DROP & !s_abort & !oversize.
//  A beat is written at mem_waddr, and then spec_bin increments.
//  oversize = PKT_MODE & (spec_bin - commit_bin == DEPTH) & s_valid & !s_last.
//  States (PKT_MODE=1):
//   - IDLE: spec_bin == commit_bin.
//     accept & !last -> PKT; accept & last -> commit, stay IDLE.
//   - PKT: accept & last -> commit -> IDLE.
//     abort or oversize on a beat -> rewind; go to DROP if !s_last, else IDLE.
//   - DROP: discard beats until an accepted beat has s_last -> IDLE.
//     s_abort is ignored while in DROP.
//  Commit:
//   - commit_bin <= spec_bin+1.
//   - wptr_gray <= bin2gray(spec_bin+1), visible the cycle after the last beat.
//  Rewind:
//   - spec_bin <= commit_bin and pkt_dropped pulses; wptr_gray does not change.
//   - An abort beat with s_last also rewinds, then returns to IDLE.
//  PKT_MODE=0:
//   - Every write commits, and wptr_gray follows spec_bin one cycle later.
//   - s_last and s_abort are ignored; state stays IDLE.
//  A simultaneous read-pointer advance and write use registered values (conservative).
//  full and free_cnt are never optimistic.
// STRUCTURE
//  async_fifo_pkg holds the wr_state_e enum (IDLE, PKT, DROP) and function bin2gray.
//  One sub-module: gray2bin #(ADDR_W+1) converts rptr_gray_sync.
//  No other hierarchy.
// TESTING (ADDR_W=3, DEPTH=8, AFULL_THRESH=2)
//  - 3-beat packet, rptr=0 -> mem_waddr 0,1,2; wptr_gray stays 0000 until the cycle after last, then 0010.
//  - 4-beat packet with s_abort on beat 2, PKT_MODE=1 ->
//    1 write; spec rewinds to 0; pkt_dropped=1 for 1 cycle;
//    beats 3-4 consumed with mem_wen=0; wptr_gray unchanged.
//  - 8 one-beat packets, rptr=0 -> full=1, s_ready=0, free_cnt=0, almost_full=1;
//    then rptr_gray_sync=0001 -> full=0 and free_cnt=1 one cycle later.
//  - 9-beat packet, no read -> beat 9 triggers oversize rewind and DROP, pkt_dropped pulses;
//    IDLE follows after s_last; wptr_gray=0.
//  - 20 one-beat writes with the reader trailing by 2 -> pointer wraps 1111->0000;
//    full never asserts and wptr_gray matches the Gray sequence.
//  - rst_n low mid-packet at spec_bin=5, commit_bin=3 -> all pointers 0, IDLE, s_ready=1, free_cnt=8.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// ----------------------------------------------------------------------------
// async_fifo_pkg
//   Shared types and helpers for the async FIFO.
//   - wr_state_e : write-controller packet state (IDLE, PKT, DROP)
//   - bin2gray   : binary to Gray code conversion. It works on a wide vector,
//                  and callers cast to their own pointer width.
// ----------------------------------------------------------------------------
package async_fifo_pkg;

    localparam int MAX_PTR_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT  = 2'd1,
        DROP = 2'd2
    } wr_state_e;

    // Zero-extending the input leaves the low Gray bits unchanged. A caller can
    // therefore truncate the result back to its own pointer width.
    function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray2bin.sv
// ----------------------------------------------------------------------------
// gray2bin
//   Combinational Gray code to binary converter.
//   Ports:
//     gray  in  W  Gray-coded value
//     bin   out W  binary equivalent
// ----------------------------------------------------------------------------
module gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    // Binary bit i is the XOR of all Gray bits at position i and above.
    always_comb begin
        bin = '0;
        for (int i = 0; i < W; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// ----------------------------------------------------------------------------
// async_fifo_wr_ctrl
//   Write-side controller of the async FIFO, in the write clock domain.
//   The block accepts a valid/ready beat stream and drives the RAM write port.
//   It keeps two write pointers. The speculative pointer (spec_bin) advances
//   on every beat written. The committed pointer (commit_bin) is the only one
//   the reader can see, and it is published as wptr_gray.
//   In packet mode, a packet becomes visible only on s_last. A packet that is
//   aborted, or that cannot fit in the FIFO, is rewound.
//   Ports:
//     clk, rst_n       write clock, async active-low reset
//     s_valid/s_ready  beat handshake; s_last ends a packet, s_abort drops it
//     rptr_gray_sync   read pointer (Gray), already synchronised to clk
//     mem_wen          RAM write enable (combinational)
//     mem_waddr        RAM write address
//     wptr_gray        committed write pointer, Gray, registered
//     full             FIFO full
//     almost_full      free_cnt <= AFULL_THRESH
//     free_cnt         free entries
//     pkt_dropped      one-cycle pulse after a packet is rewound
// ----------------------------------------------------------------------------
module async_fifo_wr_ctrl
    import async_fifo_pkg::*;
#(
    parameter int ADDR_W       = 4,
    parameter int AFULL_THRESH = 2,
    parameter int PKT_MODE     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_last,
    input  logic              s_abort,
    input  logic [ADDR_W:0]   rptr_gray_sync,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [ADDR_W:0]   wptr_gray,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   free_cnt,
    output logic              pkt_dropped
);

    localparam int              PTR_W  = ADDR_W + 1;
    localparam logic [PTR_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam bit              PKT_EN = (PKT_MODE != 0);

    wr_state_e        state_q, state_d;
    logic [PTR_W-1:0] spec_bin_q,    spec_bin_d;
    logic [PTR_W-1:0] commit_bin_q,  commit_bin_d;
    logic [PTR_W-1:0] wptr_gray_q,   wptr_gray_d;
    logic [PTR_W-1:0] rbin_q,        rbin_d;
    logic             pkt_dropped_q, pkt_dropped_d;

    logic [PTR_W-1:0] used;
    logic [PTR_W-1:0] in_flight;
    logic [PTR_W-1:0] spec_inc;
    logic             accept;
    logic             oversize;
    logic             drop_evt;

    gray2bin #(.W(PTR_W)) u_rptr_g2b (
        .gray (rptr_gray_sync),
        .bin  (rbin_d)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments only. Every flop then
    // samples the values from before the clock edge, whatever order the
    // statements are in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            spec_bin_q    <= '0;
            commit_bin_q  <= '0;
            wptr_gray_q   <= '0;
            rbin_q        <= '0;
            pkt_dropped_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            spec_bin_q    <= spec_bin_d;
            commit_bin_q  <= commit_bin_d;
            wptr_gray_q   <= wptr_gray_d;
            rbin_q        <= rbin_d;
            pkt_dropped_q <= pkt_dropped_d;
        end
    end

    // Output and handshake logic. The occupancy is computed from the
    // speculative pointer and the registered read pointer. full and free_cnt
    // therefore never run ahead of what the reader has actually freed.
    always_comb begin
        used        = spec_bin_q - rbin_q;
        in_flight   = spec_bin_q - commit_bin_q;
        full        = (used == DEPTH);
        free_cnt    = DEPTH - used;
        almost_full = (int'(free_cnt) <= AFULL_THRESH);
        // While in DROP, beats are swallowed even when the FIFO is full.
        s_ready     = (state_q == DROP) || !full;
        accept      = s_valid && s_ready;
        // When an unfinished packet already fills the RAM, it can never
        // commit. The check is qualified by s_valid rather than by accept,
        // because s_ready is already low at that point. Qualifying by accept
        // would deadlock the stream.
        oversize    = PKT_EN && (in_flight == DEPTH) && s_valid && !s_last;
        drop_evt    = PKT_EN && (state_q != DROP) && ((accept && s_abort) || oversize);
        mem_wen     = accept && (state_q != DROP) && !(PKT_EN && s_abort) && !oversize;
        mem_waddr   = spec_bin_q[ADDR_W-1:0];
        wptr_gray   = wptr_gray_q;
        pkt_dropped = pkt_dropped_q;
    end

    // Next-state logic.
    // NOTE: every signal is assigned a default before any branch. A path that
    // misses an assignment would otherwise infer a latch.
    always_comb begin
        state_d       = state_q;
        spec_bin_d    = spec_bin_q;
        commit_bin_d  = commit_bin_q;
        wptr_gray_d   = wptr_gray_q;
        pkt_dropped_d = 1'b0;
        spec_inc      = spec_bin_q + 1'b1;

        if (!PKT_EN) begin
            state_d = IDLE;
            if (mem_wen) begin
                spec_bin_d   = spec_inc;
                commit_bin_d = spec_inc;
                wptr_gray_d  = PTR_W'(bin2gray(MAX_PTR_W'(spec_inc)));
            end
        end else begin
            unique case (state_q)
                IDLE, PKT: begin
                    if (drop_evt) begin
                        // Rewind. The published pointer is left untouched.
                        spec_bin_d    = commit_bin_q;
                        pkt_dropped_d = 1'b1;
                        state_d       = (accept && s_last) ? IDLE : DROP;
                    end else if (mem_wen) begin
                        spec_bin_d = spec_inc;
                        if (s_last) begin
                            commit_bin_d = spec_inc;
                            wptr_gray_d  = PTR_W'(bin2gray(MAX_PTR_W'(spec_inc)));
                            state_d      = IDLE;
                        end else begin
                            state_d = PKT;
                        end
                    end
                end
                DROP: begin
                    if (accept && s_last) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
module tb_async_fifo_wr_ctrl;

    localparam int ADDR_W = 3;
    localparam int PTR_W  = ADDR_W + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              s_valid, s_ready, s_last, s_abort;
    logic [PTR_W-1:0]  rptr_gray_sync;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_waddr;
    logic [PTR_W-1:0]  wptr_gray;
    logic              full, almost_full, pkt_dropped;
    logic [PTR_W-1:0]  free_cnt;

    async_fifo_wr_ctrl #(
        .ADDR_W       (ADDR_W),
        .AFULL_THRESH (2),
        .PKT_MODE     (1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_last         (s_last),
        .s_abort        (s_abort),
        .rptr_gray_sync (rptr_gray_sync),
        .mem_wen        (mem_wen),
        .mem_waddr      (mem_waddr),
        .wptr_gray      (wptr_gray),
        .full           (full),
        .almost_full    (almost_full),
        .free_cnt       (free_cnt),
        .pkt_dropped    (pkt_dropped)
    );

    always #5 clk = ~clk;

    int                n_cmp = 0;
    int                n_bad = 0;
    logic [ADDR_W-1:0] exp_q[$];
    int                sb_spec = 0;
    int                sb_commit = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [PTR_W-1:0] g(input int b);
        logic [PTR_W-1:0] x;
        x = PTR_W'(b);
        return x ^ (x >> 1);
    endfunction

    // Scoreboard consumer: each RAM write must match the next expected address.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_wen === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_wen", 32'd1, 32'd0);
            else                   check("waddr", 32'(mem_waddr), 32'(exp_q.pop_front()));
        end
    end

    // Drive one beat for one clock. If wr is set, the model expects a RAM write.
    task automatic send(input bit v, input bit l, input bit a, input bit wr);
        s_valid = v; s_last = l; s_abort = a;
        if (wr) begin
            exp_q.push_back(ADDR_W'(sb_spec));
            sb_spec++;
            if (l) sb_commit = sb_spec;
        end
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0; s_abort = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_abort = 1'b0; rptr_gray_sync = '0;
        idle(2);
        check("rst_wptr", 32'(wptr_gray), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_free", 32'(free_cnt), 32'd8);
        check("rst_afull", 32'(almost_full), 32'd0);
        check("rst_drop", 32'(pkt_dropped), 32'd0);
        check("rst_wen", 32'(mem_wen), 32'd0);
        check("rst_ready", 32'(s_ready), 32'd1);
        rst_n = 1'b1;
        idle(1);

        // 3-beat packet: the pointer is published only after the last beat.
        send(1, 0, 0, 1); check("p3_wptr_b1", 32'(wptr_gray), 32'd0);
        send(1, 0, 0, 1); check("p3_wptr_b2", 32'(wptr_gray), 32'd0);
        send(1, 1, 0, 1); check("p3_wptr_done", 32'(wptr_gray), 32'(4'b0010));
        check("p3_free", 32'(free_cnt), 32'd5);
        rptr_gray_sync = g(3);
        check("rd_lag_free", 32'(free_cnt), 32'd5);
        idle(1);
        check("rd_free", 32'(free_cnt), 32'd8);

        // Aborted packet: one write, then a rewind and two discarded beats.
        send(1, 0, 0, 1);
        send(1, 0, 1, 0); sb_spec = sb_commit;
        check("ab_pulse", 32'(pkt_dropped), 32'd1);
        check("ab_free", 32'(free_cnt), 32'd8);
        send(1, 0, 0, 0);
        check("ab_pulse_end", 32'(pkt_dropped), 32'd0);
        send(1, 1, 0, 0);
        check("ab_wptr", 32'(wptr_gray), 32'(g(3)));

        // Eight one-beat packets fill the FIFO.
        for (int i = 0; i < 8; i++) send(1, 1, 0, 1);
        check("fill_full", 32'(full), 32'd1);
        check("fill_ready", 32'(s_ready), 32'd0);
        check("fill_free", 32'(free_cnt), 32'd0);
        check("fill_afull", 32'(almost_full), 32'd1);
        check("fill_wptr", 32'(wptr_gray), 32'(g(11)));
        send(1, 1, 0, 0);
        rptr_gray_sync = g(4);
        check("free1_lag", 32'(full), 32'd1);
        idle(1);
        check("free1_full", 32'(full), 32'd0);
        check("free1_cnt", 32'(free_cnt), 32'd1);
        check("free1_afull", 32'(almost_full), 32'd1);
        rptr_gray_sync = g(11);
        idle(1);
        check("drain_free", 32'(free_cnt), 32'd8);

        // 9-beat packet: the ninth beat cannot fit, so the packet is dropped.
        for (int i = 0; i < 8; i++) send(1, 0, 0, 1);
        check("ovs_full", 32'(full), 32'd1);
        check("ovs_nopulse", 32'(pkt_dropped), 32'd0);
        send(1, 0, 0, 0); sb_spec = sb_commit;
        check("ovs_pulse", 32'(pkt_dropped), 32'd1);
        check("ovs_free", 32'(free_cnt), 32'd8);
        send(1, 0, 0, 0);
        check("ovs_pulse_end", 32'(pkt_dropped), 32'd0);
        send(1, 1, 0, 0);
        check("ovs_wptr", 32'(wptr_gray), 32'(g(11)));
        send(1, 1, 0, 1);
        check("post_ovs_wptr", 32'(wptr_gray), 32'(g(12)));

        // 20 writes with the reader trailing; the pointer wraps.
        for (int i = 0; i < 20; i++) begin
            rptr_gray_sync = g(sb_spec - 1);
            send(1, 1, 0, 1);
            check("wrap_full", 32'(full), 32'd0);
            check("wrap_wptr", 32'(wptr_gray), 32'(g(sb_spec)));
        end

        // Reset in the middle of a packet, with spec at 5 and commit at 3.
        rptr_gray_sync = g(sb_spec);
        idle(1);
        for (int i = 0; i < 3; i++) send(1, 1, 0, 1);
        send(1, 0, 0, 1);
        send(1, 0, 0, 1);
        check("mid_free", 32'(free_cnt), 32'd3);
        rptr_gray_sync = '0;
        rst_n = 1'b0;
        #1;
        check("mr_wptr", 32'(wptr_gray), 32'd0);
        check("mr_ready", 32'(s_ready), 32'd1);
        check("mr_free", 32'(free_cnt), 32'd8);
        check("mr_full", 32'(full), 32'd0);
        sb_spec = 0; sb_commit = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(1, 1, 0, 1);
        check("mr_after_wptr", 32'(wptr_gray), 32'(g(1)));

        idle(2);
        check("sb_left", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
